mips_control_unit: RTL and testbench
====================================

Name: mips_control_unit

Overview:
- Multicycle main-control FSM for the MIPS datapath.
- Decodes Opcode/Funct from the instruction register and drives every datapath select, load and reset strobe: PC, IR, MDR, A, B, ALUOut, register bank, memory, ALU.
- Sits beside the datapath top; the only feedback it takes is ALU_zero and ALU_overflow.
- Moore outputs: decoded from the current state and the wait counter only.

Parameters:
- MEM_WAIT_CYCLES, 1: extra cycles a memory read needs before MemData is valid (0..7).
- EXC_VECTOR, 32'h0000_00FC: PC value loaded on exception (optional feature only).

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low
- Opcode  in  6  Instr31_26 from IR
- Funct  in  6  Instr15_0[5:0] from IR
- ALU_zero  in  1  ALU zero flag
- ALU_overflow  in  1  ALU overflow flag
- PC_load  out  1  PC write enable; equals PCWrite | (PCWriteCond & ALU_zero)
- PCSource  out  2  00 ALU_result, 01 AluOut, 10 JMP_address, 11 EPC/vector
- IorD  out  1  0 = PC addresses memory, 1 = AluOut addresses memory
- wr  out  1  memory write strobe
- IR_load  out  1  IR write
- MDR_load  out  1  MDR write
- A_load, B_load  out  1 each  operand register writes
- ALUOut_load  out  1  ALUOut write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = shifted imm
- ALU_sel  out  3  001 add, 010 sub, 011 and, 110 xor
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = AluOut, 1 = MDR
- RegWrite  out  1  register bank write
- DP_reset  out  1  active-high synchronous reset to all datapath registers
- EPC_load  out  1  EPC write (optional feature only, else tied 0)
- State  out  4  current state encoding, for debug

Behaviour:
- Reset low → state RST immediately, wait counter cleared. While in RST: DP_reset=1, all other strobes 0, selects 0.
- RST → FETCH on the first clock edge after Reset rises. DP_reset is asserted for exactly one cycle after release.
- Wait counter (3 bits) stretches each memory read to MEM_WAIT_CYCLES+1 cycles; it clears whenever the state changes.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_sel=add, PCSource=00.
  - On the final count only: IR_load=1, PCWrite=1.
  - Then → DECODE.
- DECODE:
  - A_load=1, B_load=1, ALUSrcA=0, ALUSrcB=11, ALU_sel=add, ALUOut_load=1 (branch target).
  - Dispatch on Opcode:
    - 000000 → R_EXEC
    - 100011 lw, 101011 sw → MEM_ADDR
    - 000100 beq → BRANCH
    - 000010 j → JUMP
    - 001000 addi → I_EXEC
    - other → ILLEGAL
- R_EXEC:
  - ALUSrcA=1, ALUSrcB=00, ALUOut_load=1.
  - ALU_sel from Funct: 100000 add, 100010 sub, 100100 and, 100110 xor.
  - Unknown Funct → ILLEGAL; otherwise → R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add, ALUOut_load=1. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: IorD=1; MDR_load=1 on the final count → LW_WB.
- LW_WB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEM_WRITE: IorD=1, wr=1 for one cycle → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, add, ALUOut_load=1 → I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- ILLEGAL (feature off): no strobes, treated as NOP → FETCH.
- Cycle counts at MEM_WAIT_CYCLES=1: R/addi/sw 5, lw 7, beq/j 4. Each added wait cycle adds 1 to every instruction (2 for lw).
- Invariants:
  - RegWrite, wr and PC_load are never asserted in the same cycle as DP_reset.
  - wr and MDR_load are never both 1.
- Reset mid-instruction aborts with no further strobes; no partial write completes after Reset falls.

Optional Feature:
- Macro: MIPS_CTRL_EXCEPTION_EN.
- Enabled:
  - ILLEGAL and an overflow in R_EXEC (add/sub) or I_EXEC → state EXC.
  - On overflow, RegWrite is suppressed: the write-back state is skipped.
  - EXC: ALUSrcA=0, ALUSrcB=01, ALU_sel=sub (PC-4), EPC_load=1 for one cycle → EXC_JMP.
  - EXC_JMP: PCSource=11, PCWrite=1 (EXC_VECTOR) → FETCH.
- Disabled: EXC states are absent, EPC_load is tied 0, overflow is ignored, and illegal encodings behave as NOP.

Test Plan:
- Hold Reset=0 for 3 cycles, release → DP_reset=1 for 1 cycle, then FETCH with IR_load=1 and PC_load=1 on cycle 2 of FETCH (W=1).
- R-type add (Opcode 0, Funct 0x20) → State sequence FETCH,FETCH,DECODE,R_EXEC,R_WB; RegWrite=1, RegDst=1 only in cycle 5.
- lw (0x23) with MEM_WAIT_CYCLES=3 → MEM_READ lasts 4 cycles; MDR_load pulses once in the last; total 11 cycles.
- beq (0x04) with ALU_zero=1 → PC_load=1, PCSource=01 in BRANCH. Repeat with ALU_zero=0 → PC_load=0.
- Reset dropped during MEM_WRITE → wr falls the same cycle (asynchronously); the FSM restarts at RST.
- With MIPS_CTRL_EXCEPTION_EN: addi with ALU_overflow=1 → no RegWrite, EPC_load pulse, then PC_load with PCSource=11, back to FETCH. Opcode 0x3F → same EXC path; without the macro → NOP, 4 cycles.

Source files
------------

// File: rtl/mips_control_unit.sv
// Multicycle MIPS main-control FSM: Moore decode of every datapath strobe from state and wait counter.
// Define MIPS_CTRL_EXCEPTION_EN to add the EXC/EXC_JMP overflow and illegal-opcode trap path.
module mips_control_unit #(
    parameter int unsigned MEM_WAIT_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_00FC
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       ALU_zero,
    input  logic       ALU_overflow,
    output logic       PC_load,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       wr,
    output logic       IR_load,
    output logic       MDR_load,
    output logic       A_load,
    output logic       B_load,
    output logic       ALUOut_load,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_sel,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       DP_reset,
    output logic       EPC_load,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,  S_FETCH   = 4'd1,  S_DECODE  = 4'd2,  S_R_EXEC  = 4'd3,
        S_R_WB     = 4'd4,  S_MEM_ADDR = 4'd5, S_MEM_READ = 4'd6, S_LW_WB  = 4'd7,
        S_MEM_WRITE = 4'd8, S_BRANCH  = 4'd9,  S_JUMP    = 4'd10, S_I_EXEC  = 4'd11,
        S_I_WB     = 4'd12, S_ILLEGAL = 4'd13, S_EXC     = 4'd14, S_EXC_JMP = 4'd15
    } state_e;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT_CYCLES);

    if (MEM_WAIT_CYCLES > 7 || EXC_VECTOR[1:0] != 2'b00) begin : g_param_check
        $error("mips_control_unit: MEM_WAIT_CYCLES must be 0..7 and EXC_VECTOR word aligned");
    end

    state_e     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       last_cnt;
    logic       funct_ok;
    logic [2:0] r_alu_sel;
    logic       pc_write, pc_write_cond;

    assign last_cnt = (wait_q == WAIT_LAST);

    // NOTE: every always_comb variable gets a default first, so no path can infer a latch.
    always_comb begin
        r_alu_sel = ALU_NONE;
        funct_ok  = 1'b1;
        case (Funct)
            6'b100000: r_alu_sel = ALU_ADD;
            6'b100010: r_alu_sel = ALU_SUB;
            6'b100100: r_alu_sel = ALU_AND;
            6'b100110: r_alu_sel = ALU_XOR;
            default:   funct_ok  = 1'b0;
        endcase
    end

`ifdef MIPS_CTRL_EXCEPTION_EN
    logic r_trap;
    assign r_trap = ALU_overflow && (Funct == 6'b100000 || Funct == 6'b100010);
`else
    logic unused_overflow;
    assign unused_overflow = ALU_overflow;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  if (last_cnt) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    6'b000000:            state_d = S_R_EXEC;
                    6'b100011, 6'b101011: state_d = S_MEM_ADDR;
                    6'b000100:            state_d = S_BRANCH;
                    6'b000010:            state_d = S_JUMP;
                    6'b001000:            state_d = S_I_EXEC;
                    default:              state_d = S_ILLEGAL;
                endcase
            end
`ifdef MIPS_CTRL_EXCEPTION_EN
            S_R_EXEC:  state_d = !funct_ok ? S_ILLEGAL : (r_trap ? S_EXC : S_R_WB);
            S_I_EXEC:  state_d = ALU_overflow ? S_EXC : S_I_WB;
            S_ILLEGAL: state_d = S_EXC;
            S_EXC:     state_d = S_EXC_JMP;
            S_EXC_JMP: state_d = S_FETCH;
`else
            S_R_EXEC:  state_d = funct_ok ? S_R_WB : S_ILLEGAL;
            S_I_EXEC:  state_d = S_I_WB;
            S_ILLEGAL: state_d = S_FETCH;
`endif
            S_MEM_ADDR: state_d = (Opcode == 6'b101011) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: if (last_cnt) state_d = S_LW_WB;
            S_R_WB, S_LW_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
            default:    state_d = S_RST;
        endcase
    end

    // The wait counter only advances while a memory-read state holds itself.
    assign wait_d = (state_d != state_q) ? 3'd0 : wait_q + 3'd1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_RST;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        PCSource      = 2'b00;
        IorD          = 1'b0;
        wr            = 1'b0;
        IR_load       = 1'b0;
        MDR_load      = 1'b0;
        A_load        = 1'b0;
        B_load        = 1'b0;
        ALUOut_load   = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALU_sel       = ALU_NONE;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        DP_reset      = 1'b0;
        EPC_load      = 1'b0;
        case (state_q)
            S_RST: DP_reset = 1'b1;
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                ALU_sel  = ALU_ADD;
                IR_load  = last_cnt;
                pc_write = last_cnt;
            end
            S_DECODE: begin
                A_load      = 1'b1;
                B_load      = 1'b1;
                ALUSrcB     = 2'b11;
                ALU_sel     = ALU_ADD;
                ALUOut_load = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA     = 1'b1;
                ALU_sel     = r_alu_sel;
                ALUOut_load = 1'b1;
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALU_sel     = ALU_ADD;
                ALUOut_load = 1'b1;
            end
            S_MEM_READ: begin
                IorD     = 1'b1;
                MDR_load = last_cnt;
            end
            S_LW_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD = 1'b1;
                wr   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALU_sel       = ALU_SUB;
                pc_write_cond = 1'b1;
                PCSource      = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSource = 2'b10;
            end
            S_I_WB: RegWrite = 1'b1;
`ifdef MIPS_CTRL_EXCEPTION_EN
            S_EXC: begin
                ALUSrcB  = 2'b01;
                ALU_sel  = ALU_SUB;
                EPC_load = 1'b1;
            end
            S_EXC_JMP: begin
                pc_write = 1'b1;
                PCSource = 2'b11;
            end
`endif
            default: ;
        endcase
    end

    assign PC_load = pc_write | (pc_write_cond & ALU_zero);
    assign State   = state_q;

endmodule

// File: tb/tb_mips_control_unit.sv
// Scoreboard bench for mips_control_unit: per-cycle expected strobe vectors are queued from a
// reference table and compared on the falling clock edge. Covers W=1 and W=3 instances.
module tb_mips_control_unit;

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_R_EXEC = 4'd3,
        S_R_WB = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_READ = 4'd6, S_LW_WB = 4'd7, S_MEM_WRITE = 4'd8,
        S_BRANCH = 4'd9, S_JUMP = 4'd10, S_I_EXEC = 4'd11, S_I_WB = 4'd12, S_ILLEGAL = 4'd13,
        S_EXC = 4'd14, S_EXC_JMP = 4'd15;
`ifdef MIPS_CTRL_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] state;
        logic       dp_reset, pc_load, ir_load, mdr_load, wr, reg_write, reg_dst, mem_to_reg;
        logic       epc_load, a_load, b_load, aluout_load, iord, src_a;
        logic [1:0] src_b, pc_source;
        logic [2:0] alu_sel;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;

    logic       Clk = 1'b0;
    logic       rst1_n = 1'b0, rst3_n = 1'b0;
    logic [5:0] Opcode = 6'd0, Funct = 6'd0;
    logic       ALU_zero = 1'b0, ALU_overflow = 1'b0;
    bit         sel3 = 1'b0;

    logic       pcl1, irl1, mdrl1, wr1, al1, bl1, aol1, iord1, sa1, rd1, m2r1, rw1, dpr1, epc1;
    logic [1:0] pcs1, sb1;
    logic [2:0] alu1;
    logic [3:0] st1;
    logic       pcl3, irl3, mdrl3, wr3, al3, bl3, aol3, iord3, sa3, rd3, m2r3, rw3, dpr3, epc3;
    logic [1:0] pcs3, sb3;
    logic [2:0] alu3;
    logic [3:0] st3;

    obs_t obs1, obs3, obs;
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 Clk = ~Clk;

    mips_control_unit #(.MEM_WAIT_CYCLES(1)) dut (
        .Clk(Clk), .Reset(rst1_n), .Opcode(Opcode), .Funct(Funct),
        .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow),
        .PC_load(pcl1), .PCSource(pcs1), .IorD(iord1), .wr(wr1), .IR_load(irl1),
        .MDR_load(mdrl1), .A_load(al1), .B_load(bl1), .ALUOut_load(aol1), .ALUSrcA(sa1),
        .ALUSrcB(sb1), .ALU_sel(alu1), .RegDst(rd1), .MemtoReg(m2r1), .RegWrite(rw1),
        .DP_reset(dpr1), .EPC_load(epc1), .State(st1)
    );

    mips_control_unit #(.MEM_WAIT_CYCLES(3)) dut3 (
        .Clk(Clk), .Reset(rst3_n), .Opcode(Opcode), .Funct(Funct),
        .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow),
        .PC_load(pcl3), .PCSource(pcs3), .IorD(iord3), .wr(wr3), .IR_load(irl3),
        .MDR_load(mdrl3), .A_load(al3), .B_load(bl3), .ALUOut_load(aol3), .ALUSrcA(sa3),
        .ALUSrcB(sb3), .ALU_sel(alu3), .RegDst(rd3), .MemtoReg(m2r3), .RegWrite(rw3),
        .DP_reset(dpr3), .EPC_load(epc3), .State(st3)
    );

    assign obs1 = {st1, dpr1, pcl1, irl1, mdrl1, wr1, rw1, rd1, m2r1, epc1, al1, bl1, aol1,
                   iord1, sa1, sb1, pcs1, alu1};
    assign obs3 = {st3, dpr3, pcl3, irl3, mdrl3, wr3, rw3, rd3, m2r3, epc3, al3, bl3, aol3,
                   iord3, sa3, sb3, pcs3, alu3};
    assign obs  = sel3 ? obs3 : obs1;

    // Reference strobe table, written from the state descriptions.
    function automatic obs_t model(input logic [3:0] s, input bit last, input bit zero,
                                   input logic [5:0] fn);
        obs_t e = '0;
        e.state = s;
        case (s)
            S_RST:    e.dp_reset = 1'b1;
            S_FETCH:  begin e.src_b = 2'b01; e.alu_sel = 3'b001; e.ir_load = last; e.pc_load = last; end
            S_DECODE: begin
                e.a_load = 1'b1; e.b_load = 1'b1; e.aluout_load = 1'b1;
                e.src_b = 2'b11; e.alu_sel = 3'b001;
            end
            S_R_EXEC: begin
                e.src_a = 1'b1; e.aluout_load = 1'b1;
                case (fn)
                    6'h20: e.alu_sel = 3'b001;
                    6'h22: e.alu_sel = 3'b010;
                    6'h24: e.alu_sel = 3'b011;
                    6'h26: e.alu_sel = 3'b110;
                    default: e.alu_sel = 3'b000;
                endcase
            end
            S_R_WB:   begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            S_MEM_ADDR, S_I_EXEC: begin
                e.src_a = 1'b1; e.src_b = 2'b10; e.alu_sel = 3'b001; e.aluout_load = 1'b1;
            end
            S_MEM_READ:  begin e.iord = 1'b1; e.mdr_load = last; end
            S_LW_WB:     begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
            S_MEM_WRITE: begin e.iord = 1'b1; e.wr = 1'b1; end
            S_BRANCH: begin
                e.src_a = 1'b1; e.alu_sel = 3'b010; e.pc_source = 2'b01; e.pc_load = zero;
            end
            S_JUMP:    begin e.pc_load = 1'b1; e.pc_source = 2'b10; end
            S_I_WB:    e.reg_write = 1'b1;
            S_EXC:     begin e.src_b = 2'b01; e.alu_sel = 3'b010; e.epc_load = 1'b1; end
            S_EXC_JMP: begin e.pc_load = 1'b1; e.pc_source = 2'b11; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic push(input string tag, input logic [3:0] s, input bit last);
        exp_t it;
        it.tag = tag;
        it.v   = model(s, last, ALU_zero, Funct);
        sb.push_back(it);
    endtask

    task automatic check_pop();
        exp_t it;
        it = sb.pop_front();
        n_total++;
        assert (obs === it.v) n_pass++;
        else $error("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                    it.tag, obs, obs.state, it.v, it.v.state);
    endtask

    task automatic run_queue();
        while (sb.size() > 0) begin
            @(negedge Clk);
            check_pop();
        end
    endtask

    task automatic push_exc(input string tag);
        push(tag, S_EXC, 1'b0);
        push(tag, S_EXC_JMP, 1'b0);
    endtask

    // Sets the IR fields and flags, queues the full expected per-cycle trace, then checks it.
    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input bit zero, input bit ovf, input int w);
        bit fn_ok, fn_arith;
        Opcode = op; Funct = fn; ALU_zero = zero; ALU_overflow = ovf;
        fn_ok    = (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h26);
        fn_arith = (fn == 6'h20 || fn == 6'h22);
        for (int i = 0; i <= w; i++) push(tag, S_FETCH, i == w);
        push(tag, S_DECODE, 1'b0);
        case (op)
            6'h00: begin
                push(tag, S_R_EXEC, 1'b0);
                if (!fn_ok) begin
                    push(tag, S_ILLEGAL, 1'b0);
                    if (EXC_EN) push_exc(tag);
                end else if (EXC_EN && ovf && fn_arith) push_exc(tag);
                else push(tag, S_R_WB, 1'b0);
            end
            6'h23: begin
                push(tag, S_MEM_ADDR, 1'b0);
                for (int i = 0; i <= w; i++) push(tag, S_MEM_READ, i == w);
                push(tag, S_LW_WB, 1'b0);
            end
            6'h2B: begin push(tag, S_MEM_ADDR, 1'b0); push(tag, S_MEM_WRITE, 1'b0); end
            6'h04: push(tag, S_BRANCH, 1'b0);
            6'h02: push(tag, S_JUMP, 1'b0);
            6'h08: begin
                push(tag, S_I_EXEC, 1'b0);
                if (EXC_EN && ovf) push_exc(tag);
                else push(tag, S_I_WB, 1'b0);
            end
            default: begin
                push(tag, S_ILLEGAL, 1'b0);
                if (EXC_EN) push_exc(tag);
            end
        endcase
        run_queue();
        ALU_overflow = 1'b0;
    endtask

    task automatic do_reset(input bit use3);
        sel3 = use3;
        if (use3) rst3_n = 1'b0; else rst1_n = 1'b0;
        repeat (3) begin
            push("reset_hold", S_RST, 1'b0);
            run_queue();
        end
        @(posedge Clk);
        #1;
        if (use3) rst3_n = 1'b1; else rst1_n = 1'b1;
        push("reset_release", S_RST, 1'b0);
        run_queue();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(1'b0);
        instr("r_add",      6'h00, 6'h20, 1'b0, 1'b0, 1);
        instr("r_sub",      6'h00, 6'h22, 1'b0, 1'b0, 1);
        instr("r_and",      6'h00, 6'h24, 1'b0, 1'b0, 1);
        instr("r_xor",      6'h00, 6'h26, 1'b0, 1'b0, 1);
        instr("r_bad_fn",   6'h00, 6'h07, 1'b0, 1'b0, 1);
        instr("lw",         6'h23, 6'h00, 1'b0, 1'b0, 1);
        instr("sw",         6'h2B, 6'h00, 1'b0, 1'b0, 1);
        instr("beq_taken",  6'h04, 6'h00, 1'b1, 1'b0, 1);
        instr("beq_not",    6'h04, 6'h00, 1'b0, 1'b0, 1);
        instr("j",          6'h02, 6'h00, 1'b0, 1'b0, 1);
        instr("addi",       6'h08, 6'h00, 1'b0, 1'b0, 1);
        instr("addi_ovf",   6'h08, 6'h00, 1'b0, 1'b1, 1);
        instr("r_add_ovf",  6'h00, 6'h20, 1'b0, 1'b1, 1);
        instr("illegal_3f", 6'h3F, 6'h00, 1'b0, 1'b0, 1);

        // Reset dropped while wr is high must kill wr in the same cycle.
        Opcode = 6'h2B; Funct = 6'h00; ALU_zero = 1'b0;
        push("sw_abort", S_FETCH, 1'b0);
        push("sw_abort", S_FETCH, 1'b1);
        push("sw_abort", S_DECODE, 1'b0);
        push("sw_abort", S_MEM_ADDR, 1'b0);
        push("sw_abort", S_MEM_WRITE, 1'b0);
        run_queue();
        #1 rst1_n = 1'b0;
        #1;
        push("sw_abort_async", S_RST, 1'b0);
        check_pop();
        do_reset(1'b0);
        instr("j_after_abort", 6'h02, 6'h00, 1'b0, 1'b0, 1);

        // Second instance: three extra memory wait cycles.
        rst1_n = 1'b0;
        do_reset(1'b1);
        instr("lw_w3",    6'h23, 6'h00, 1'b0, 1'b0, 3);
        instr("r_add_w3", 6'h00, 6'h20, 1'b0, 1'b0, 3);
        instr("beq_w3",   6'h04, 6'h00, 1'b1, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
